mem_arbiter_multiciclo: RTL
===========================

# mem_arbiter_multiciclo

Two-port arbiter sharing the single unified instruction/data memory of the multicycle CPU between the CPU memory port (port 0) and an auxiliary master (port 1: DMA, debug loader or display reader). Arbitration is round-robin, one memory transaction at a time, with a ready/ack handshake towards the memory and a timeout watchdog. While the CPU's request is pending, the multicycle control unit holds its state on `oAck0` low.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 15, maximum ACCESS cycles before abort. Must be ≥1.

Ports:
- `iCLK`  in  1  system clock; all state updates on the rising edge.
- `iRST`  in  1  asynchronous, active-low reset.
- `iReq0` / `iReq1`  in  1  transaction request, port 0 / 1.
- `iWe0` / `iWe1`  in  1  1 = write, 0 = read.
- `iAddr0` / `iAddr1`  in  ADDR_W  byte address.
- `iWData0` / `iWData1`  in  DATA_W  write data.
- `oRData0` / `oRData1`  out  DATA_W  registered read data, valid while `oAckN` = 1.
- `oAck0` / `oAck1`  out  1  one-cycle transaction-complete pulse.
- `oErr0` / `oErr1`  out  1  one-cycle timeout flag, asserted together with `oAckN`.
- `oGrant`  out  2  one-hot owner of the current transaction; 0 when idle.
- `oMemRe`, `oMemWe`  out  1  memory read / write strobes.
- `oMemAddr`  out  ADDR_W  memory address.
- `oMemWData`  out  DATA_W  memory write data.
- `iMemRData`  in  DATA_W  memory read data.
- `iMemAck`  in  1  memory completion; rdata is valid in the same cycle.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** `iReq0`/`iReq1` are sampled.
  - With a single requester, that port is granted.
  - With both requesting, the port not granted last wins.
  - The last-grant pointer resets to port 1, so port 0 wins the first tie.
  - On a grant: latch we/addr/wdata of the winner into internal registers, set `oGrant`, update the pointer, clear the counter, and go to ACCESS.
- **ACCESS:**
  - `oMemRe` = ~we_latched and `oMemWe` = we_latched.
  - `oMemAddr` and `oMemWData` are driven from the latched registers.
  - The counter increments every cycle.
  - On `iMemAck`, for a read, `iMemRData` is captured into the owner's `oRDataN`, then go to RESP.
  - If the counter equals TIMEOUT and `iMemAck` = 0: set the error flag and go to RESP. `oRDataN` is unchanged.
  - If `iMemAck` arrives in the same cycle the counter reaches TIMEOUT, the ack wins and there is no error.
- **RESP:**
  - The owner's `oAckN` = 1 (and `oErrN` if flagged) for exactly one cycle.
  - Memory strobes are 0 and `oGrant` is cleared.
  - Go to IDLE.
- **Requester rules:**
  - A requester holds req and its fields stable until its ack. Fields are latched at grant, so later changes are ignored.
  - Dropping req before ack does not abort; the transaction completes and the ack is still issued.
  - Req high in the cycle after `oAckN` is treated as a new request, which allows back-to-back accesses.
- **Writes:** `oRDataN` is unchanged on writes.
- The counter width is $clog2(TIMEOUT+1) and it never wraps.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, the pointer is port 1 and the counter is 0.
- **Reset mid-transaction:** memory strobes and `oGrant` drop asynchronously, and no ack or err is produced.
- Request to first strobe: 1 cycle (IDLE→ACCESS).
- Ack to `oAckN`: 1 cycle (RESP).
- Minimum transaction is 3 cycles (IDLE, ACCESS with ack, RESP). The maximum is TIMEOUT+3.
- Memory strobes are asserted only in ACCESS.
- `oAck0` and `oAck1` are never high in the same cycle.
- A losing requester waits at most one full transaction of the other port.
- All outputs are registered or decoded from the state register only. There is no combinational path from `iReqN` to the outputs.

## Structure
- State encodings (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2) and the default ARB_TIMEOUT go in the shared Parametros.v.
- A single combinational sub-module, `arb_rr2`, is natural. It maps (req0, req1, last) to a one-hot grant.
- The FSM, latches and watchdog stay in the top module.

## Test plan
- **Single read:** `iReq0`=1, we=0, addr=0x0000_0040, memory acks on the 2nd ACCESS cycle with 0xDEAD_BEEF.
  - `oMemRe` is seen for 2 cycles.
  - `oAck0` pulses once with `oRData0`=0xDEAD_BEEF.
  - `oGrant`=01 during ACCESS.
- **Tie, round-robin:** both ports request from reset, held for 4 transactions, immediate acks.
  - Grant order is 0,1,0,1.
  - Each transaction takes 3 cycles.
  - `oAck0`/`oAck1` alternate and never overlap.
- **Write:** `iReq1`, we=1, addr=0x2000, wdata=0x1234_5678.
  - `oMemWe`=1 with matching addr and data.
  - `oRData1` is unchanged after `oAck1`.
- **Timeout:** TIMEOUT=15, no `iMemAck`.
  - ACCESS lasts 16 cycles.
  - `oAck0`=`oErr0`=1 for one cycle.
  - `oRData0` keeps its previous value.
  - The next request proceeds normally.
- **Boundary ack:** ack asserted exactly when the counter = TIMEOUT.
  - `oAck`=1, `oErr`=0, and rdata is captured.
- **Async reset mid-ACCESS:** drop `iRST` asynchronously between clock edges during ACCESS.
  - `oMemRe`/`oGrant` go to 0 immediately and no ack follows.
  - After release, a pending tie grants port 0 first.

Source files
------------

// File: rtl/mem_arbiter_multiciclo_pkg.sv
// Shared definitions for the unified-memory arbiter of the multicycle CPU.
//   ARB_TIMEOUT : default watchdog limit, in ACCESS cycles
//   arbState_t  : arbiter FSM state encoding
package mem_arbiter_multiciclo_pkg;

  localparam int unsigned ARB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arbState_t;

endpackage

// File: rtl/mem_arbiter_multiciclo_arb_rr2.sv
// Two-input round-robin grant decoder (purely combinational).
//   req0/req1 : pending requests
//   last      : port granted last time (1 = port 1)
//   grant_c   : one-hot winner, bit 0 = port 0; 0 when nobody requests
module arb_rr2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] grant_c
);

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_c = 2'b00;
    if (req0 && req1) begin
      grant_c = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant_c = 2'b01;
    end else if (req1) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter_multiciclo.sv
// Round-robin arbiter sharing one memory between the CPU (port 0) and an
// auxiliary master (port 1), one transaction at a time, with watchdog.
//   iReqN/iWeN/iAddrN/iWDataN : requester side, fields latched at grant
//   oRDataN/oAckN/oErrN       : registered response, ack/err one-cycle pulse
//   oGrant                    : one-hot owner while in ACCESS
//   oMemRe/oMemWe/oMemAddr/oMemWData, iMemRData/iMemAck : memory side
module mem_arbiter_multiciclo
  import mem_arbiter_multiciclo_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic              iWe0,
  input  logic              iWe1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData0,
  input  logic [DATA_W-1:0] iWData1,
  output logic [DATA_W-1:0] oRData0,
  output logic [DATA_W-1:0] oRData1,
  output logic              oAck0,
  output logic              oAck1,
  output logic              oErr0,
  output logic              oErr1,
  output logic [1:0]        oGrant,
  output logic              oMemRe,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  input  logic              iMemAck
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arbState_t         state, stateNxt;
  logic              lastGrant, lastNxt;
  logic              owner, ownerNxt;
  logic              weLat, weNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] wdataNxt;
  logic [DATA_W-1:0] rdata0Nxt, rdata1Nxt;
  logic              ack0Nxt, ack1Nxt, err0Nxt, err1Nxt;
  logic [1:0]        grantNxt;
  logic              memReNxt, memWeNxt;
  logic [1:0]        winGrant;
  logic              timeoutHit;

  arb_rr2 uArb (
    .req0    (iReq0),
    .req1    (iReq1),
    .last    (lastGrant),
    .grant_c (winGrant)
  );

  assign timeoutHit = (cnt == CNT_W'(TIMEOUT));

  // Next-state and next-output logic; oMemAddr/oMemWData double as the
  // latched request fields.
  always_comb begin
    stateNxt  = state;
    lastNxt   = lastGrant;
    ownerNxt  = owner;
    weNxt     = weLat;
    cntNxt    = cnt;
    addrNxt   = oMemAddr;
    wdataNxt  = oMemWData;
    rdata0Nxt = oRData0;
    rdata1Nxt = oRData1;
    ack0Nxt   = 1'b0;
    ack1Nxt   = 1'b0;
    err0Nxt   = 1'b0;
    err1Nxt   = 1'b0;
    grantNxt  = oGrant;
    memReNxt  = oMemRe;
    memWeNxt  = oMemWe;

    case (state)
      ST_IDLE: begin
        if (winGrant != 2'b00) begin
          stateNxt = ST_ACCESS;
          ownerNxt = winGrant[1];
          lastNxt  = winGrant[1];
          cntNxt   = '0;
          grantNxt = winGrant;
          weNxt    = winGrant[1] ? iWe1 : iWe0;
          addrNxt  = winGrant[1] ? iAddr1 : iAddr0;
          wdataNxt = winGrant[1] ? iWData1 : iWData0;
          memReNxt = ~weNxt;
          memWeNxt = weNxt;
        end
      end

      ST_ACCESS: begin
        // Saturating watchdog; an ack in the timeout cycle still wins.
        if (!timeoutHit) begin
          cntNxt = cnt + CNT_W'(1);
        end
        if (iMemAck || timeoutHit) begin
          stateNxt = ST_RESP;
          grantNxt = 2'b00;
          memReNxt = 1'b0;
          memWeNxt = 1'b0;
          ack0Nxt  = ~owner;
          ack1Nxt  = owner;
          if (!iMemAck) begin
            err0Nxt = ~owner;
            err1Nxt = owner;
          end else if (!weLat) begin
            if (owner) begin
              rdata1Nxt = iMemRData;
            end else begin
              rdata0Nxt = iMemRData;
            end
          end
        end
      end

      ST_RESP: begin
        stateNxt = ST_IDLE;
      end

      default: begin
        stateNxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= ST_IDLE;
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      weLat     <= 1'b0;
      cnt       <= '0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oRData0   <= '0;
      oRData1   <= '0;
      oAck0     <= 1'b0;
      oAck1     <= 1'b0;
      oErr0     <= 1'b0;
      oErr1     <= 1'b0;
      oGrant    <= 2'b00;
      oMemRe    <= 1'b0;
      oMemWe    <= 1'b0;
    end else begin
      state     <= stateNxt;
      lastGrant <= lastNxt;
      owner     <= ownerNxt;
      weLat     <= weNxt;
      cnt       <= cntNxt;
      oMemAddr  <= addrNxt;
      oMemWData <= wdataNxt;
      oRData0   <= rdata0Nxt;
      oRData1   <= rdata1Nxt;
      oAck0     <= ack0Nxt;
      oAck1     <= ack1Nxt;
      oErr0     <= err0Nxt;
      oErr1     <= err1Nxt;
      oGrant    <= grantNxt;
      oMemRe    <= memReNxt;
      oMemWe    <= memWeNxt;
    end
  end

endmodule
